ex_mem_ctrl_fwd: RTL and testbench
==================================

Name: ex_mem_ctrl_fwd

Overview:
Pipeline-support block for the 5-stage RV64 core. It combines three functions:
- combinational main-control decode of the ID-stage opcode;
- the EX/MEM pipeline register, which also produces the branch-taken signal pcsrc;
- the EX-stage forwarding unit, which compares EX source registers against the MEM- and WB-stage destinations.

Parameters:
XLEN, 64, datapath width of PC, ALU result and store data.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_opcode  in  7  ID-stage instruction bits [6:0]
alu_src  out  1  ALU operand B selects immediate
mem_to_reg  out  1  writeback selects memory data
reg_write  out  1  instruction writes rd
mem_read  out  1  load
mem_write  out  1  store
branch  out  1  conditional branch
alu_op  out  2  ALU-control class
ex_branch_target  in  XLEN  EX-stage PC + immediate
ex_alu_result  in  XLEN  ALU result
ex_store_data  in  XLEN  forwarded rs2 value
ex_rd  in  5  EX destination register
ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  in  1 each  EX control bits
ex_zero  in  1  ALU zero flag
ex_rs1, ex_rs2  in  5 each  EX source registers
wb_rd  in  5  WB destination register
wb_reg_write  in  1  WB write enable
mem_branch_target, mem_alu_result, mem_store_data  out  XLEN each  registered copies
mem_rd  out  5  registered copy
mem_mem_to_reg, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch, mem_zero  out  1 each  registered copies
pcsrc  out  1  mem_branch AND mem_zero
forward_a, forward_b  out  2 each  operand forwarding selects

Behaviour:
Control decode is purely combinational on id_opcode. Outputs are listed as alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op:
- 0110011 (R-type): 0,0,1,0,0,0,10
- 0000011 (ld): 1,1,1,1,0,0,00
- 0100011 (sd): 1,0,0,0,1,0,00
- 1100011 (beq): 0,0,0,0,0,1,01
- Any other opcode: all outputs 0, alu_op 00. No X outputs.

EX/MEM register:
- Every mem_* output captures its ex_* counterpart on each rising clk edge.
- No stall or flush input; it loads every cycle.
- When rst_n is low, all mem_* outputs clear to 0 immediately, with no clock needed, and stay 0 while rst_n is low.
- The first capture occurs on the first rising edge after rst_n goes high.
- Latency is one cycle from ex_* to mem_*.

pcsrc is combinational: mem_branch & mem_zero. It is 0 during reset.

Forwarding unit (combinational; uses the registered mem_rd and mem_reg_write). The forward_a rule, with the same rule for forward_b using ex_rs2:
- 10 if mem_reg_write=1, mem_rd!=0 and mem_rd==ex_rs1 (forward the MEM ALU result).
- Else 01 if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1 (forward the WB write data).
- Else 00 (use the register-file value).
- 11 is never produced.
- MEM has priority over WB when both match.
- Register x0 never forwards.
- During reset, mem_reg_write=0, so only the WB match can produce a nonzero select.

Decomposition:
Shared package ex_mem_pkg holds:
- opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH;
- ALUOp constants ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10;
- forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.

One natural sub-module, ex_mem_pipe_reg, is the asynchronously cleared register bank. Decode and forwarding stay as combinational logic in the top.

Test Plan:
- Opcode sweep 0110011/0000011/0100011/1100011/1111111 -> control vectors exactly as tabled; 1111111 gives all zeros.
- rst_n=0 mid-run with ex_alu_result=0x1234, ex_branch=1, ex_zero=1 -> all mem_* and pcsrc go to 0 at once without a clock edge. After release, one edge gives mem_alu_result=0x1234 and pcsrc=1.
- Pipeline capture: ex_rd=5, ex_reg_write=1, ex_alu_result=0xDEAD, then one edge -> mem_rd=5, mem_alu_result=0xDEAD. Changing ex_* with no edge leaves the outputs unchanged.
- Forwarding priority: mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1, ex_rs1=3, ex_rs2=4 -> forward_a=10, forward_b=00. Then wb_rd=4 -> forward_b=01.
- x0 guard: mem_rd=0, mem_reg_write=1, wb_rd=0, wb_reg_write=1, ex_rs1=0 -> forward_a=00.
- Write-enable gating: mem_rd=7, mem_reg_write=0, ex_rs2=7, wb_reg_write=0 -> forward_b=00.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared constants and forwarding helper for the EX/MEM block
package ex_mem_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM wins over WB; x0 is hardwired zero so it never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - asynchronously cleared EX/MEM register bank
module ex_mem_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = data_i;
    assign data_o = data_q;

    // Load every cycle; reset clears immediately without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ex_mem_ctrl_fwd.sv
// rtl/ex_mem_ctrl_fwd.sv - main control decode, EX/MEM register and EX forwarding
module ex_mem_ctrl_fwd
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      id_opcode,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic [1:0]      alu_op,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_to_reg,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_branch,
    input  logic            ex_zero,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    output logic [XLEN-1:0] mem_branch_target,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_mem_to_reg,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_branch,
    output logic            mem_zero,
    output logic            pcsrc,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b
);

    localparam int PIPE_W = 3 * XLEN + 5 + 6;

    logic [PIPE_W-1:0] pipe_d;
    logic [PIPE_W-1:0] pipe_q;

    // Decode the ID opcode; unknown opcodes behave as a bubble.
    always_comb begin
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_op     = ALUOP_MEM;
        case (id_opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_R;
            end
            OP_LOAD: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_STORE: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = ALUOP_BR;
            end
            default: ;
        endcase
    end

    assign pipe_d = {ex_branch_target, ex_alu_result, ex_store_data, ex_rd,
                     ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_branch, ex_zero};

    ex_mem_pipe_reg #(
        .WIDTH (PIPE_W)
    ) u_pipe_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (pipe_d),
        .data_o (pipe_q)
    );

    assign {mem_branch_target, mem_alu_result, mem_store_data, mem_rd,
            mem_mem_to_reg, mem_reg_write, mem_mem_read, mem_mem_write,
            mem_branch, mem_zero} = pipe_q;

    assign pcsrc = mem_branch & mem_zero;

    // Forwarding looks at the registered MEM destination and the WB destination.
    always_comb begin
        forward_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        forward_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: tb/tb_ex_mem_ctrl_fwd.sv
// tb/tb_ex_mem_ctrl_fwd.sv - self-checking bench for ex_mem_ctrl_fwd
module tb_ex_mem_ctrl_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  id_opcode;
    logic        alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [63:0] ex_branch_target, ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2, wb_rd;
    logic        ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_zero;
    logic        wb_reg_write;
    logic [63:0] mem_branch_target, mem_alu_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_mem_to_reg, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch, mem_zero;
    logic        pcsrc;
    logic [1:0]  forward_a, forward_b;

    int passed = 0;
    int total  = 0;

    // Model of the MEM stage contents.
    logic [63:0] m_bt, m_alu, m_sd;
    logic [4:0]  m_rd;
    logic        m_mtr, m_rw, m_mr, m_mw, m_br, m_z;

    ex_mem_ctrl_fwd #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .alu_op(alu_op),
        .ex_branch_target(ex_branch_target), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .mem_branch_target(mem_branch_target), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .pcsrc(pcsrc),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control vector from the opcode table: {alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
    function automatic logic [7:0] ref_ctrl(input logic [6:0] op);
        if (op == 7'b0110011) return 8'b0010_0010;
        if (op == 7'b0000011) return 8'b1111_0000;
        if (op == 7'b0100011) return 8'b1000_1000;
        if (op == 7'b1100011) return 8'b0000_0101;
        return 8'b0;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] mrd,
                                           input logic mwe, input logic [4:0] wrd, input logic wwe);
        if (mwe && mrd != 0 && mrd == rs) return 2'd2;
        if (wwe && wrd != 0 && wrd == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_clear();
        {m_bt, m_alu, m_sd, m_rd, m_mtr, m_rw, m_mr, m_mw, m_br, m_z} = '0;
    endtask

    // One clock edge; model captures EX inputs if out of reset.
    task automatic step();
        if (rst_n) begin
            m_bt = ex_branch_target; m_alu = ex_alu_result; m_sd = ex_store_data;
            m_rd = ex_rd; m_mtr = ex_mem_to_reg; m_rw = ex_reg_write;
            m_mr = ex_mem_read; m_mw = ex_mem_write; m_br = ex_branch; m_z = ex_zero;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        check({tag, ".bt"},  mem_branch_target, m_bt);
        check({tag, ".alu"}, mem_alu_result, m_alu);
        check({tag, ".sd"},  mem_store_data, m_sd);
        check({tag, ".ctl"}, {mem_rd, mem_mem_to_reg, mem_reg_write, mem_mem_read,
                              mem_mem_write, mem_branch, mem_zero},
                             {m_rd, m_mtr, m_rw, m_mr, m_mw, m_br, m_z});
        check({tag, ".pcsrc"}, pcsrc, m_br & m_z);
    endtask

    task automatic check_fwd(input string tag);
        check({tag, ".fa"}, forward_a, ref_fwd(ex_rs1, m_rd, m_rw, wb_rd, wb_reg_write));
        check({tag, ".fb"}, forward_b, ref_fwd(ex_rs2, m_rd, m_rw, wb_rd, wb_reg_write));
    endtask

    task automatic check_ctrl(input string tag);
        check(tag, {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op},
              ref_ctrl(id_opcode));
    endtask

    logic [6:0] ops [5];

    initial begin
        ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
        ops[3] = 7'b1100011; ops[4] = 7'b1111111;
        rst_n = 1'b0;
        id_opcode = '0;
        {ex_branch_target, ex_alu_result, ex_store_data} = '0;
        {ex_rd, ex_rs1, ex_rs2, wb_rd} = '0;
        {ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_zero} = '0;
        wb_reg_write = 1'b0;
        model_clear();

        // Reset state, including a WB-only forward during reset.
        ex_reg_write = 1'b1; ex_rd = 5'd9; ex_alu_result = 64'h55;
        ex_rs1 = 5'd6; wb_rd = 5'd6; wb_reg_write = 1'b1;
        #1;
        check_mem("reset");
        check("reset.fa_wb", forward_a, 2'd1);
        step();
        check_mem("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode sweep.
        foreach (ops[i]) begin
            id_opcode = ops[i];
            #1;
            check_ctrl($sformatf("ctrl_%b", ops[i]));
        end
        check("ctrl_ff_zero", {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}, 8'd0);

        // Pipeline capture and hold without an edge.
        ex_rd = 5'd5; ex_reg_write = 1'b1; ex_alu_result = 64'hDEAD;
        step();
        check("cap.rd", mem_rd, 5'd5);
        check("cap.alu", mem_alu_result, 64'hDEAD);
        ex_rd = 5'd12; ex_alu_result = 64'hBEEF; ex_store_data = 64'h77;
        #3;
        check("hold.rd", mem_rd, 5'd5);
        check("hold.alu", mem_alu_result, 64'hDEAD);

        // Asynchronous reset mid-run.
        ex_alu_result = 64'h1234; ex_branch = 1'b1; ex_zero = 1'b1;
        step();
        check("pre_rst.pcsrc", pcsrc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_mem("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst.alu", mem_alu_result, 64'h1234);
        check("post_rst.pcsrc", pcsrc, 1'b1);

        // Forwarding priority.
        ex_rd = 5'd3; ex_reg_write = 1'b1;
        step();
        wb_rd = 5'd3; wb_reg_write = 1'b1; ex_rs1 = 5'd3; ex_rs2 = 5'd4;
        #1;
        check("prio.fa", forward_a, 2'd2);
        check("prio.fb", forward_b, 2'd0);
        wb_rd = 5'd4;
        #1;
        check("prio.fb_wb", forward_b, 2'd1);

        // x0 guard.
        ex_rd = 5'd0; ex_reg_write = 1'b1;
        step();
        wb_rd = 5'd0; wb_reg_write = 1'b1; ex_rs1 = 5'd0;
        #1;
        check("x0.fa", forward_a, 2'd0);

        // Write-enable gating.
        ex_rd = 5'd7; ex_reg_write = 1'b0;
        step();
        wb_rd = 5'd7; wb_reg_write = 1'b0; ex_rs2 = 5'd7;
        #1;
        check("gate.fb", forward_b, 2'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            id_opcode = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 4)] : 7'($urandom);
            ex_branch_target = {$urandom, $urandom};
            ex_alu_result    = {$urandom, $urandom};
            ex_store_data    = {$urandom, $urandom};
            ex_rd = 5'($urandom_range(0, 7));
            {ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_zero} = 6'($urandom);
            #1;
            check_ctrl("rnd.ctrl");
            step();
            check_mem("rnd");
            ex_rs1 = 5'($urandom_range(0, 7));
            ex_rs2 = 5'($urandom_range(0, 7));
            wb_rd  = 5'($urandom_range(0, 7));
            wb_reg_write = 1'($urandom);
            #1;
            check_fwd("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
